frame_writer: RTL and testbench

//  Producer side of the double-buffered 32x24 block framebuffer. Accepts an RGB332 pixel stream
//  (valid/ready, start-of-frame marker), generates row-major write addresses 0..PIXEL_COUNT-1 into
//  the back buffer, and paces frames to the display swap so a new frame is never written into the

---
 rtl/frame_writer.sv | 170 +++++++++++++++++
 tb/tb_frame_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// Producer side of the ping-pong block framebuffer: turns a pixel stream
// into row-major back-buffer writes and paces frames to the display swap.
module frame_writer #(
  parameter int PIXEL_COUNT = 768,
  parameter int ADDR_WIDTH  = 20,
  parameter int FCNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            vga_hc,
  input  logic [9:0]            vga_vc,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  pix_sof,
  input  logic [7:0]            pix_data,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic                  frame_done,
  output logic [FCNT_WIDTH-1:0] frame_count,
  output logic                  overrun,
  output logic                  resync
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);
  localparam logic [FCNT_WIDTH-1:0] FONE =
    FCNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    done_q, done_d;
  logic [FCNT_WIDTH-1:0]   fcnt_q, fcnt_d;
  logic                    ovr_q, ovr_d;
  logic                    rsy_q, rsy_d;
  logic                    swap_cond_q;

  logic swap_cond;
  logic swap;
  logic accept;
  logic is_last;

  assign swap_cond = (vga_hc == 10'd0) && (vga_vc == 10'd0);
  // Only the first cycle of the origin counts, so a held
  // condition cannot release two frames.
  assign swap      = swap_cond & ~swap_cond_q;
  assign pix_ready = (state_q != S_HOLD);
  assign accept    = pix_valid & pix_ready;
  assign is_last   = (cnt_q == LAST);

  assign write_en    = we_q;
  assign write_addr  = addr_q;
  assign write_data  = data_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
  assign overrun     = ovr_q;
  assign resync      = rsy_q;

  // Swap edge detector history; starts high so reset at the
  // origin does not fake a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cond_q <= 1'b1;
    end else begin
      swap_cond_q <= swap_cond;
    end
  end

  // Next-state, write generation and status flag updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    ovr_d   = ovr_q;
    rsy_d   = rsy_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && pix_sof) begin
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = pix_data;
          cnt_d   = ONE;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (accept && pix_sof) begin
          we_d   = 1'b1;
          addr_d = '0;
          data_d = pix_data;
          cnt_d  = ONE;
          rsy_d  = 1'b1;
          if (swap) begin
            ovr_d = 1'b1;
          end
        end else if (accept && is_last) begin
          // Completing frame wins over a coincident swap:
          // it waits for the next swap to be shown.
          we_d    = 1'b1;
          addr_d  = cnt_q;
          data_d  = pix_data;
          cnt_d   = '0;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + FONE;
          state_d = S_HOLD;
        end else begin
          if (accept) begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = pix_data;
            cnt_d  = cnt_q + ONE;
          end
          if (swap) begin
            ovr_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (swap) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      ovr_q   <= 1'b0;
      rsy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
      rsy_q   <= rsy_d;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Randomized bench for frame_writer against a frame-level
// reference model of the stream/swap rules.
module tb_frame_writer;

  localparam int PC = 768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  vga_hc = 10'd1;
  logic [9:0]  vga_vc = 10'd1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        write_en;
  logic [19:0] write_addr;
  logic [7:0]  write_data;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        overrun;
  logic        resync;

  frame_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_hc     (vga_hc),
    .vga_vc     (vga_vc),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_data   (pix_data),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .overrun    (overrun),
    .resync     (resync)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the producer.
  bit          m_prev;
  bit          m_hold;
  bit          m_fill;
  int          pos;
  bit          e_we;
  int          e_addr;
  logic [7:0]  e_data;
  bit          e_done;
  int          e_frames;
  bit          e_ovr;
  bit          e_rsy;

  task automatic model_reset();
    m_prev = 1'b1;
    m_hold = 1'b0;
    m_fill = 1'b0;
    pos    = 0;
    e_we   = 1'b0;
    e_done = 1'b0;
    e_frames = 0;
    e_ovr  = 1'b0;
    e_rsy  = 1'b0;
  endtask

  task automatic step(input bit v, input bit s,
                      input logic [7:0] d, input bit sw);
    bit swp;
    bit acc;
    bit last;
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    vga_hc = sw ? 10'd0 : 10'($urandom_range(1, 799));
    vga_vc = sw ? 10'd0 : 10'($urandom_range(0, 524));
    swp = sw && !m_prev;
    m_prev = sw;
    acc = v && !m_hold;
    #1;
    chk("pix_ready", 32'(pix_ready), 32'(!m_hold));
    e_we = 1'b0;
    e_done = 1'b0;
    last = 1'b0;
    if (m_hold) begin
      if (swp) m_hold = 1'b0;
    end else if (!m_fill) begin
      if (acc && s) begin
        e_we = 1'b1; e_addr = 0; e_data = d;
        m_fill = 1'b1; pos = 1;
      end
    end else begin
      if (acc && s) begin
        e_rsy = 1'b1;
        e_we = 1'b1; e_addr = 0; e_data = d;
        pos = 1;
      end else if (acc) begin
        e_we = 1'b1; e_addr = pos; e_data = d;
        if (pos == PC - 1) begin
          e_done = 1'b1;
          e_frames++;
          m_fill = 1'b0;
          m_hold = 1'b1;
          pos = 0;
          last = 1'b1;
        end else begin
          pos++;
        end
      end
      if (swp && !last) e_ovr = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("write_en", 32'(write_en), 32'(e_we));
    if (e_we) begin
      chk("write_addr", 32'(write_addr), 32'(e_addr));
      chk("write_data", 32'(write_data), 32'(e_data));
    end
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_count", 32'(frame_count),
        32'(e_frames % 256));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    chk("resync", 32'(resync), 32'(e_rsy));
  endtask

  // Stream one frame; optional swap/sof injected at given slot.
  task automatic run_frame(input int sw_pos, input int sof_pos,
                           input bit rnd);
    int  guard = 0;
    bit  sw_used = 1'b0;
    bit  sof_used = 1'b0;
    bit  v, s, sw;
    logic [7:0] d;
    int  p;
    while (!m_hold && guard < 6000) begin
      v = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      s = 1'b0;
      sw = 1'b0;
      p = pos;
      if (v && !m_fill) s = 1'b1;
      if (v && m_fill && !sof_used && sof_pos >= 0
          && p == sof_pos) begin
        s = 1'b1;
        sof_used = 1'b1;
      end
      if (m_fill && !sw_used && sw_pos >= 0 && p == sw_pos) begin
        sw = 1'b1;
        sw_used = 1'b1;
      end
      d = rnd ? 8'($urandom) : (s ? 8'd0 : 8'(p));
      step(v, s, d, sw);
      guard++;
    end
    if (guard >= 6000) chk("frame_timeout", 32'(1), 32'(0));
  endtask

  task automatic swap_held(input int n);
    for (int i = 0; i < n; i++)
      step(bit'($urandom_range(0, 1)), 1'b0, 8'($urandom), 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(write_en), 32'(0));
    chk("rst_ready", 32'(pix_ready), 32'(1));
    chk("rst_fcnt", 32'(frame_count), 32'(0));
    chk("rst_ovr", 32'(overrun), 32'(0));
    chk("rst_rsy", 32'(resync), 32'(0));
    #18 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pre-sof pixels in IDLE are dropped.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b0);

    // Back-to-back frame with data = addr[7:0].
    run_frame(-1, -1, 1'b0);
    chk("frames_after_first", 32'(frame_count), 32'(1));
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
    // Held origin: a single release to IDLE.
    swap_held(5);

    // Random gaps.
    run_frame(-1, -1, 1'b1);
    swap_held(1);

    // Swap mid-fill.
    run_frame(400, -1, 1'b0);
    chk("overrun_set", 32'(overrun), 32'(1));
    swap_held(2);

    // Resync mid-fill.
    run_frame(-1, 100, 1'b1);
    chk("resync_set", 32'(resync), 32'(1));
    swap_held(1);

    // Swap coincident with the last pixel.
    run_frame(PC - 1, -1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b1);
    step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b0, 8'($urandom), 1'b0);
    swap_held(1);

    // Reset mid-stream.
    step(1'b1, 1'b1, 8'h5a, 1'b0);
    for (int i = 0; i < 50; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
    pix_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(write_en), 32'(0));
    chk("mid_rst_ready", 32'(pix_ready), 32'(1));
    chk("mid_rst_fcnt", 32'(frame_count), 32'(0));
    chk("mid_rst_ovr", 32'(overrun), 32'(0));
    chk("mid_rst_rsy", 32'(resync), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
    run_frame(-1, -1, 1'b1);
    swap_held(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
